// File: rtl/psk_frame_scheduler.sv
// PSK frame scheduler: buffers 16-bit sequence words and steps them out MSB first, one symbol per SYM_DIV+1 clocks,
// aligning each symbol advance to a carrier zero crossing (with timeout). Optional differential encoding: PSK_DIFF_ENC_EN.
module psk_frame_scheduler #(
    parameter int SYM_DIV = 9765,
    parameter int ZC_WIN  = 50
) (
    input  logic        clk_100M,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [15:0] word_in,
    input  logic        word_valid,
    output logic        word_ready,
    input  logic [15:0] carrier,
    output logic [15:0] sequenceCode,
    output logic [3:0]  sym_idx,
    output logic        sym_bit,
    output logic        sym_strobe,
    output logic        busy,
    output logic        underrun
);

    localparam int CW = $clog2(SYM_DIV + 2);

    typedef enum logic [2:0] {IDLE, LOAD, WAIT_TICK, WAIT_ZC, ADVANCE} state_t;

    state_t          state, nxt;
    logic [15:0]     fifo_mem [2];
    logic            wr_ptr, rd_ptr, rdy_en;
    logic [1:0]      fifo_cnt;
    logic            push, pop, fifo_empty;
    logic [CW-1:0]   sym_cnt, zc_cnt;
    logic            tick, zc_timeout, in_win;
    logic signed [16:0] zc_diff, zc_abs;
    logic [15:0]     head, enc;
    logic            strobe_nxt, underrun_nxt;

    // word_ready stays low until the first edge after reset release
    assign word_ready = rdy_en & (fifo_cnt != 2'd2);
    assign push       = word_valid & word_ready;
    assign pop        = (state == LOAD);
    assign fifo_empty = (fifo_cnt == 2'd0);
    assign head       = fifo_mem[rd_ptr];

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en   <= 1'b0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            rdy_en <= 1'b1;
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            fifo_cnt <= fifo_cnt + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge clk_100M) begin
        if (push) fifo_mem[wr_ptr] <= word_in;
    end

    // Window test done signed so carriers below mid-scale cannot wrap
    assign zc_diff = $signed({1'b0, carrier}) - 17'sd32767;
    assign zc_abs  = (zc_diff < 0) ? -zc_diff : zc_diff;
    assign in_win  = (zc_abs <= $signed(17'(ZC_WIN)));

    assign tick       = (sym_cnt == CW'(SYM_DIV));
    assign zc_timeout = (zc_cnt == CW'(SYM_DIV));

`ifdef PSK_DIFF_ENC_EN
    logic prev_bit;
    always_comb begin
        logic b;
        enc = '0;
        b   = prev_bit;
        for (int i = 15; i >= 0; i--) begin
            b      = head[i] ^ b;
            enc[i] = b;
        end
    end

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n)
            prev_bit <= 1'b0;
        else if (nxt == IDLE && state != IDLE)
            prev_bit <= 1'b0;
        else if (state == ADVANCE && sym_idx == 4'd0)
            prev_bit <= sequenceCode[0];
    end
`else
    assign enc = head;
`endif

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:      if (enable && !fifo_empty) nxt = LOAD;
            LOAD:      nxt = WAIT_TICK;
            WAIT_TICK: if (tick) nxt = in_win ? ADVANCE : WAIT_ZC;
            WAIT_ZC:   if (in_win || zc_timeout) nxt = ADVANCE;
            ADVANCE: begin
                if (sym_idx != 4'd0)            nxt = WAIT_TICK;
                else if (enable && !fifo_empty) nxt = LOAD;
                else                            nxt = IDLE;
            end
            default:   nxt = IDLE;
        endcase
    end

    always_comb begin
        busy         = (state != IDLE);
        sym_bit      = busy ? sequenceCode[sym_idx] : 1'b0;
        strobe_nxt   = (state == LOAD) || (state == ADVANCE && sym_idx != 4'd0);
        underrun_nxt = (state == ADVANCE) && (sym_idx == 4'd0) && enable && fifo_empty;
    end

    // Counter restarts when LOAD is entered so the LOAD cycle is count 0 of the first symbol
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            sym_cnt      <= '0;
            zc_cnt       <= '0;
            sequenceCode <= 16'h0000;
            sym_idx      <= 4'd15;
            sym_strobe   <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            sym_cnt    <= (state == IDLE || nxt == LOAD || tick) ? '0 : sym_cnt + CW'(1);
            zc_cnt     <= (state == WAIT_ZC) ? zc_cnt + CW'(1) : '0;
            sym_strobe <= strobe_nxt;
            underrun   <= underrun_nxt;
            if (state == LOAD) begin
                sequenceCode <= enc;
                sym_idx      <= 4'd15;
            end else if (state == ADVANCE) begin
                if (sym_idx != 4'd0)  sym_idx <= sym_idx - 4'd1;
                else if (nxt == IDLE) sym_idx <= 4'd15;
            end
        end
    end

endmodule

// File: tb/tb_psk_frame_scheduler.sv
// Directed bench for psk_frame_scheduler with a short symbol period (SYM_DIV=9, 10 clocks per symbol).
module tb_psk_frame_scheduler;

    localparam bit DIFF =
`ifdef PSK_DIFF_ENC_EN
        1'b1;
`else
        1'b0;
`endif

    logic        clk_100M = 1'b0;
    logic        rst_n, enable, word_valid, word_ready;
    logic [15:0] word_in, carrier, sequenceCode;
    logic [3:0]  sym_idx;
    logic        sym_bit, sym_strobe, busy, underrun;

    int checks   = 0;
    int failures = 0;

    always #5 clk_100M = ~clk_100M;

    psk_frame_scheduler #(.SYM_DIV(9), .ZC_WIN(50)) dut (
        .clk_100M     (clk_100M),
        .rst_n        (rst_n),
        .enable       (enable),
        .word_in      (word_in),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .carrier      (carrier),
        .sequenceCode (sequenceCode),
        .sym_idx      (sym_idx),
        .sym_bit      (sym_bit),
        .sym_strobe   (sym_strobe),
        .busy         (busy),
        .underrun     (underrun)
    );

    function automatic logic [15:0] enc_word(input logic [15:0] d, input logic p);
        logic [15:0] e;
        logic        b;
        e = '0;
        b = p;
        for (int i = 15; i >= 0; i--) begin
            b    = d[i] ^ b;
            e[i] = b;
        end
        return DIFF ? e : d;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_100M);
        #1;
    endtask

    task automatic wait_strobe(input int max, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!sym_strobe && n < max);
    endtask

    task automatic push(input logic [15:0] w);
        int n;
        word_in    = w;
        word_valid = 1'b1;
        n = 0;
        while (!word_ready && n < 100) begin
            step();
            n++;
        end
        step();
        word_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    logic [15:0] cv [5] = '{16'd32817, 16'd32818, 16'd32717, 16'd32716, 16'd40000};
    int          gv [5] = '{10, 20, 10, 20, 20};
    logic [15:0] wv [3] = '{16'h1234, 16'hBEEF, 16'h0F0F};

    initial begin
        int          n, s, u, idle_gaps;
        logic [15:0] pat, e0, e1, e2;
        logic [15:0] got [3];

        rst_n = 1'b0; enable = 1'b0; word_valid = 1'b0; word_in = '0; carrier = 16'd32767;
        step();
        step();
        chk("rst_seq",      32'(sequenceCode), 32'h0);
        chk("rst_idx",      32'(sym_idx),      32'd15);
        chk("rst_bit",      32'(sym_bit),      32'd0);
        chk("rst_strobe",   32'(sym_strobe),   32'd0);
        chk("rst_underrun", 32'(underrun),     32'd0);
        chk("rst_busy",     32'(busy),         32'd0);
        chk("rst_ready",    32'(word_ready),   32'd0);
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", 32'(word_ready), 32'd0);
        step();
        chk("ready_after_edge",  32'(word_ready), 32'd1);

        // Single word, carrier at mid-scale: one symbol every 10 clocks
        enable = 1'b1;
        pat = enc_word(16'hA5C3, 1'b0);
        push(16'hA5C3);
        wait_strobe(50, n);
        chk("a_load_strobe", 32'(sym_strobe), 32'd1);
        chk("a_load_idx",    32'(sym_idx),    32'd15);
        chk("a_bit15",       32'(sym_bit),    32'(pat[15]));
        for (int i = 1; i < 16; i++) begin
            wait_strobe(50, n);
            chk($sformatf("a_gap%0d", i), 32'(n),       32'd10);
            chk($sformatf("a_idx%0d", i), 32'(sym_idx), 32'(15 - i));
            chk($sformatf("a_bit%0d", i), 32'(sym_bit), 32'(pat[15 - i]));
        end
        n = 0;
        do begin step(); n++; end while (!underrun && n < 50);
        chk("a_underrun",      32'(underrun),     32'd1);
        chk("a_underrun_time", 32'(n),            32'd10);
        chk("a_idle_busy",     32'(busy),         32'd0);
        chk("a_idle_idx",      32'(sym_idx),      32'd15);
        chk("a_idle_bit",      32'(sym_bit),      32'd0);
        chk("a_idle_seq_hold", 32'(sequenceCode), 32'(pat));
        step();
        chk("a_underrun_1cyc", 32'(underrun),     32'd0);

        // Zero-crossing window edges and the timeout path
        for (int k = 0; k < 5; k++) begin
            carrier = cv[k];
            push(16'h5555);
            wait_strobe(50, n);
            wait_strobe(50, n);
            chk($sformatf("b_gap_c%0d", cv[k]), 32'(n), 32'(gv[k]));
            if (cv[k] == 16'd40000) begin
                for (int j = 0; j < 2; j++) begin
                    wait_strobe(50, n);
                    chk($sformatf("b_timeout_gap%0d", j), 32'(n), 32'd20);
                end
            end
            pulse_reset();
        end
        carrier = 16'd32767;

        // Three back-to-back words: third stalls until the first LOAD, then words run contiguously
        e0 = enc_word(wv[0], 1'b0);
        e1 = enc_word(wv[1], e0[0]);
        e2 = enc_word(wv[2], e1[0]);
        word_in = wv[0]; word_valid = 1'b1;
        chk("c_ready0", 32'(word_ready), 32'd1);
        step();
        word_in = wv[1];
        chk("c_ready1", 32'(word_ready), 32'd1);
        step();
        word_in = wv[2];
        chk("c_stall",  32'(word_ready), 32'd0);
        step();
        chk("c_release",     32'(word_ready),   32'd1);
        chk("c_load_strobe", 32'(sym_strobe),   32'd1);
        chk("c_word0",       32'(sequenceCode), 32'(e0));
        step();
        word_valid = 1'b0;
        s = 1; n = 0; idle_gaps = 0;
        got[0] = sequenceCode; got[1] = '0; got[2] = '0;
        while (s < 48 && n < 2000) begin
            step();
            n++;
            if (sym_strobe) begin
                if (s % 16 == 0) got[s / 16] = sequenceCode;
                s++;
            end
            if (!busy) idle_gaps++;
        end
        chk("c_strobes",   32'(s),         32'd48);
        chk("c_word1",     32'(got[1]),    32'(e1));
        chk("c_word2",     32'(got[2]),    32'(e2));
        chk("c_idle_gaps", 32'(idle_gaps), 32'd0);
        n = 0;
        do begin step(); n++; end while (!underrun && n < 50);
        chk("c_underrun", 32'(underrun), 32'd1);

        // Dropping enable mid-word finishes the word without underrun
        push(16'h00FF);
        wait_strobe(50, n);
        for (int j = 0; j < 3; j++) wait_strobe(50, n);
        enable = 1'b0;
        s = 4; u = 0; n = 0;
        while (busy && n < 500) begin
            step();
            n++;
            if (sym_strobe) s++;
            if (underrun) u++;
        end
        chk("d_full_word",   32'(s),    32'd16);
        chk("d_no_underrun", 32'(u),    32'd0);
        chk("d_idle",        32'(busy), 32'd0);
        enable = 1'b1;

        // Reset mid-word discards the active word and the buffered one
        push(16'hC3A5);
        push(16'h7777);
        n = 0;
        while (sym_idx != 4'd7 && n < 500) begin step(); n++; end
        chk("e_reach_idx7", 32'(sym_idx), 32'd7);
        rst_n = 1'b0;
        #1;
        chk("e_rst_seq",   32'(sequenceCode), 32'h0);
        chk("e_rst_busy",  32'(busy),         32'd0);
        chk("e_rst_idx",   32'(sym_idx),      32'd15);
        chk("e_rst_ready", 32'(word_ready),   32'd0);
        step();
        rst_n = 1'b1;
        step();
        step();
        step();
        chk("e_fifo_empty", 32'(busy),       32'd0);
        chk("e_ready_back", 32'(word_ready), 32'd1);
        push(16'h8001);
        wait_strobe(50, n);
        chk("e_new_idx", 32'(sym_idx),      32'd15);
        chk("e_new_seq", 32'(sequenceCode), 32'(enc_word(16'h8001, 1'b0)));
        pulse_reset();

        // All-ones word loaded from IDLE
        push(16'hFFFF);
        wait_strobe(50, n);
        chk("f_ffff_seq", 32'(sequenceCode), DIFF ? 32'h0000_AAAA : 32'h0000_FFFF);
        pulse_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
